data_memory_unit_param: RTL and testbench

Parametrised, byte-addressable data memory for the MIPS datapath, replacing the fixed 32-bit word memory. It supports byte, halfword and word accesses with MIPS load sign/zero extension and a valid/ready request port. A fixed, configurable read latency returns responses in order. After reset, a self-clearing init sequence zeroes the array before the first request is accepted.

---
 rtl/dmem_pkg.sv | 71 +++++++
 rtl/dmem_rsp_pipe.sv | 49 ++++
 rtl/data_memory_unit_param.sv | 145 ++++++++++++++
 tb/tb_data_memory_unit_param.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable data memory: access size
// encodings, FSM state type and the load lane-extract/extend helpers.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } dmem_state_e;

  // Pick the addressed lanes of a little-endian word and extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        zext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'h00;
    h = 16'h0000;
    r = 32'h0000_0000;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = zext ? {24'h00_0000, b} : {{24{b[7]}}, b};
      SIZE_HALF: r = zext ? {16'h0000, h} : {{16{h[15]}}, h};
      SIZE_WORD: r = word;
      default:   r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Byte-enable mask of the lanes a store touches.
  function automatic logic [31:0] store_mask(input logic [1:0] lane,
                                             input logic [1:0] size);
    logic [31:0] m;
    m = 32'h0000_0000;
    case (size)
      SIZE_BYTE: m = 32'h0000_00FF << {lane, 3'b000};
      SIZE_HALF: m = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      SIZE_WORD: m = 32'hFFFF_FFFF;
      default:   m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  // Store data replicated so the low bytes land on every candidate lane.
  function automatic logic [31:0] store_data(input logic [31:0] wdata,
                                             input logic [1:0]  size);
    logic [31:0] d;
    d = 32'h0000_0000;
    case (size)
      SIZE_BYTE: d = {4{wdata[7:0]}};
      SIZE_HALF: d = {2{wdata[15:0]}};
      SIZE_WORD: d = wdata;
      default:   d = 32'h0000_0000;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_rsp_pipe.sv
// Fixed-latency response pipeline. Stage 0 is loaded at the accept edge, so
// the last stage holds the response LATENCY-1 edges later. Data/error only
// advance with a valid entry, which lets the output hold its last response.
module dmem_rsp_pipe #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_error,
  input  logic [31:0] in_rdata,
  output logic        out_valid,
  output logic        out_error,
  output logic [31:0] out_rdata
);

  logic [LATENCY-1:0] vld_r;
  logic [LATENCY-1:0] err_r;
  logic [31:0]        dat_r [LATENCY];

  // Shift valid every cycle; move payload only behind a valid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
      err_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_r[i] <= 32'h0000_0000;
      end
    end else begin
      vld_r[0] <= in_valid;
      if (in_valid) begin
        err_r[0] <= in_error;
        dat_r[0] <= in_rdata;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
        if (vld_r[i-1]) begin
          err_r[i] <= err_r[i-1];
          dat_r[i] <= dat_r[i-1];
        end
      end
    end
  end

  assign out_valid = vld_r[LATENCY-1];
  assign out_error = err_r[LATENCY-1];
  assign out_rdata = dat_r[LATENCY-1];

endmodule

// File: rtl/data_memory_unit_param.sv
// Byte-addressable data memory with byte/half/word access, MIPS load
// extension, a self-clearing init sweep after reset and in-order responses.
module data_memory_unit_param
  import dmem_pkg::*;
#(
  parameter int DEPTH        = 256,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]      mem [DEPTH];
  dmem_state_e      state_r;
  logic [IDX_W-1:0] init_cnt_r;
  logic             ready_r;

  logic             accept_s;
  logic [IDX_W-1:0] idx_s;
  logic [1:0]       lane_s;
  logic             oor_s;
  logic             size_err_s;
  logic             err_s;
  logic [31:0]      rd_word_s;
  logic [31:0]      mask_s;
  logic [31:0]      wdat_s;
  logic             mem_we_s;
  logic [IDX_W-1:0] mem_widx_s;
  logic [31:0]      mem_wdata_s;
  logic [31:0]      rsp_in_rdata_s;

  assign req_ready = ready_r;
  assign accept_s  = req_valid && ready_r;
  assign idx_s     = req_addr[IDX_W+1:2];
  assign lane_s    = req_addr[1:0];
  // Anything at or above 4*DEPTH has a set bit above the word index.
  assign oor_s     = |(req_addr >> (IDX_W + 2));
  assign rd_word_s = mem[idx_s];
  assign mask_s    = store_mask(lane_s, req_size);
  assign wdat_s    = store_data(req_wdata, req_size);

  // Init sweep then READY; ready is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_INIT;
      init_cnt_r <= '0;
      ready_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          init_cnt_r <= init_cnt_r + IDX_W'(1);
          if (init_cnt_r == IDX_W'(DEPTH - 1)) begin
            state_r <= ST_READY;
            ready_r <= 1'b1;
          end
        end
        ST_READY: begin
          ready_r <= 1'b1;
        end
        default: begin
          state_r    <= ST_INIT;
          init_cnt_r <= '0;
          ready_r    <= 1'b0;
        end
      endcase
    end
  end

  // Size/alignment legality of the presented request.
  always_comb begin
    size_err_s = 1'b0;
    case (req_size)
      SIZE_BYTE: size_err_s = 1'b0;
      SIZE_HALF: size_err_s = req_addr[0];
      SIZE_WORD: size_err_s = (req_addr[1:0] != 2'b00);
      default:   size_err_s = 1'b1;
    endcase
    err_s = size_err_s | oor_s;
  end

  // Select the array write: init clears, otherwise a legal accepted store
  // merges its lanes into the current word.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_widx_s  = idx_s;
    mem_wdata_s = 32'h0000_0000;
    if (state_r == ST_INIT) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = init_cnt_r;
      mem_wdata_s = 32'h0000_0000;
    end else if (accept_s && req_write && !err_s) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = idx_s;
      mem_wdata_s = (rd_word_s & ~mask_s) | (wdat_s & mask_s);
    end else begin
      mem_we_s    = 1'b0;
      mem_widx_s  = idx_s;
      mem_wdata_s = 32'h0000_0000;
    end
  end

  // Memory array; contents are cleared by the init sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_widx_s] <= mem_wdata_s;
    end
  end

  // Load data for the response; stores and errors return zero.
  always_comb begin
    rsp_in_rdata_s = 32'h0000_0000;
    if (err_s || req_write) begin
      rsp_in_rdata_s = 32'h0000_0000;
    end else begin
      rsp_in_rdata_s = load_extend(rd_word_s, lane_s, req_size, req_unsigned);
    end
  end

  dmem_rsp_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_rsp_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept_s),
    .in_error  (err_s),
    .in_rdata  (rsp_in_rdata_s),
    .out_valid (rsp_valid),
    .out_error (rsp_error),
    .out_rdata (rsp_rdata)
  );

endmodule

// File: tb/tb_data_memory_unit_param.sv
// Directed bench: two memories (latency 1 and 3, DEPTH 16) share the same
// request stream; responses are captured per instance and compared to
// hand-computed expectations, including delay from accept.
module tb_data_memory_unit_param;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [1:0]  req_size = 2'b00;

  logic        rdy1, rdy3, v1, v3, e1, e3;
  logic [31:0] d1, d3;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [31:0] r1_d[$], r3_d[$], e_d[$];
  logic        r1_e[$], r3_e[$], e_e[$];
  int          r1_c[$], r3_c[$], a_c[$];

  data_memory_unit_param #(.DEPTH(16), .ADDR_WIDTH(32), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(v1), .rsp_rdata(d1), .rsp_error(e1));

  data_memory_unit_param #(.DEPTH(16), .ADDR_WIDTH(32), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy3),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(v3), .rsp_rdata(d3), .rsp_error(e3));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every response pulse with the cycle it was seen in.
  always @(negedge clk) begin
    if (v1) begin r1_d.push_back(d1); r1_e.push_back(e1); r1_c.push_back(cyc); end
    if (v3) begin r3_d.push_back(d3); r3_e.push_back(e3); r3_c.push_back(cyc); end
  end

  task automatic clear_q();
    r1_d.delete(); r1_e.delete(); r1_c.delete();
    r3_d.delete(); r3_e.delete(); r3_c.delete();
    e_d.delete();  e_e.delete();  a_c.delete();
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [1:0] s,
                      input logic u, input logic [31:0] wd,
                      input logic [31:0] xd, input logic xe);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = s;
    req_unsigned = u; req_wdata = wd;
    @(posedge clk); #1;
    a_c.push_back(cyc); e_d.push_back(xd); e_e.push_back(xe);
  endtask

  task automatic idle_settle();
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdy1 !== 1'b0 || rdy3 !== 1'b0 || v1 !== 1'b0 || v3 !== 1'b0 ||
        d1 !== 32'h0 || d3 !== 32'h0 || e1 !== 1'b0 || e3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b%b v=%b%b d=%h/%h e=%b%b, want all 0",
               rdy1, rdy3, v1, v3, d1, d3, e1, e3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rdy1 || rdy3) begin n = i; break; end
    end
    checks++;
    if (n !== 16 || rdy1 !== 1'b1 || rdy3 !== 1'b1) begin
      errors++;
      $display("FAIL init_ready_edges: got %0d edges (rdy=%b%b), want 16", n, rdy1, rdy3);
    end
  endtask

  task automatic test_init_load();
    clear_q();
    send(1'b0, 32'h14, SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
    idle_settle();
    checks++;
    if (r1_d.size() != 1 || r3_d.size() != 1) begin
      errors++;
      $display("FAIL init_load_count: got %0d/%0d, want 1/1", r1_d.size(), r3_d.size());
    end
    checks++;
    if (r1_d[0] !== 32'h0 || r1_e[0] !== 1'b0 || r3_d[0] !== 32'h0 || r3_e[0] !== 1'b0 ||
        r1_c[0] - a_c[0] != 0 || r3_c[0] - a_c[0] != 2) begin
      errors++;
      $display("FAIL init_load: got d=%h/%h e=%b%b, want 0 err 0 at delay 0/2",
               r1_d[0], r3_d[0], r1_e[0], r3_e[0]);
    end
  endtask

  task automatic test_bytes();
    clear_q();
    send(1'b1, 32'h8, SIZE_WORD, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
    send(1'b0, 32'h8, SIZE_BYTE, 1'b0, 32'h0, 32'hFFFFFFEF, 1'b0);
    send(1'b0, 32'h9, SIZE_BYTE, 1'b0, 32'h0, 32'hFFFFFFBE, 1'b0);
    send(1'b0, 32'hA, SIZE_BYTE, 1'b0, 32'h0, 32'hFFFFFFAD, 1'b0);
    send(1'b0, 32'hB, SIZE_BYTE, 1'b0, 32'h0, 32'hFFFFFFDE, 1'b0);
    send(1'b0, 32'h8, SIZE_BYTE, 1'b1, 32'h0, 32'h000000EF, 1'b0);
    send(1'b0, 32'h9, SIZE_BYTE, 1'b1, 32'h0, 32'h000000BE, 1'b0);
    send(1'b0, 32'hA, SIZE_BYTE, 1'b1, 32'h0, 32'h000000AD, 1'b0);
    send(1'b0, 32'hB, SIZE_BYTE, 1'b1, 32'h0, 32'h000000DE, 1'b0);
    idle_settle();
    checks++;
    if (r1_d.size() != e_d.size() || r3_d.size() != e_d.size()) begin
      errors++;
      $display("FAIL bytes_count: got %0d/%0d, want %0d", r1_d.size(), r3_d.size(), e_d.size());
    end
    foreach (e_d[i]) begin
      checks++;
      if (r1_d[i] !== e_d[i] || r1_e[i] !== e_e[i] || r1_c[i] - a_c[i] != 0) begin
        errors++;
        $display("FAIL bytes[%0d] lat1: got d=%h e=%b dly=%0d, want d=%h e=%b dly=0",
                 i, r1_d[i], r1_e[i], r1_c[i] - a_c[i], e_d[i], e_e[i]);
      end
      checks++;
      if (r3_d[i] !== e_d[i] || r3_e[i] !== e_e[i] || r3_c[i] - a_c[i] != 2) begin
        errors++;
        $display("FAIL bytes[%0d] lat3: got d=%h e=%b dly=%0d, want d=%h e=%b dly=2",
                 i, r3_d[i], r3_e[i], r3_c[i] - a_c[i], e_d[i], e_e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    send(1'b1, 32'hA, SIZE_HALF, 1'b0, 32'hABCD1234, 32'h0, 1'b0);
    send(1'b0, 32'h8, SIZE_WORD, 1'b0, 32'h0, 32'h1234BEEF, 1'b0);
    send(1'b0, 32'hA, SIZE_HALF, 1'b0, 32'h0, 32'h00001234, 1'b0);
    send(1'b0, 32'h8, SIZE_HALF, 1'b0, 32'h0, 32'hFFFFBEEF, 1'b0);
    idle_settle();
    checks++;
    if (r1_d.size() != e_d.size() || r3_d.size() != e_d.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d/%0d, want %0d", r1_d.size(), r3_d.size(), e_d.size());
    end
    foreach (e_d[i]) begin
      checks++;
      if (r1_d[i] !== e_d[i] || r1_e[i] !== e_e[i] || r1_c[i] - a_c[i] != 0) begin
        errors++;
        $display("FAIL b2b[%0d] lat1: got d=%h e=%b dly=%0d, want d=%h e=%b dly=0",
                 i, r1_d[i], r1_e[i], r1_c[i] - a_c[i], e_d[i], e_e[i]);
      end
      checks++;
      if (r3_d[i] !== e_d[i] || r3_e[i] !== e_e[i] || r3_c[i] - a_c[i] != 2) begin
        errors++;
        $display("FAIL b2b[%0d] lat3: got d=%h e=%b dly=%0d, want d=%h e=%b dly=2",
                 i, r3_d[i], r3_e[i], r3_c[i] - a_c[i], e_d[i], e_e[i]);
      end
    end
  endtask

  task automatic test_errors();
    clear_q();
    send(1'b0, 32'h6,  SIZE_WORD, 1'b0, 32'h0,        32'h0, 1'b1);
    send(1'b1, 32'h3,  SIZE_HALF, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
    send(1'b1, 32'h8,  SIZE_BAD,  1'b0, 32'h55555555, 32'h0, 1'b1);
    send(1'b0, 32'h8,  SIZE_BAD,  1'b0, 32'h0,        32'h0, 1'b1);
    send(1'b1, 32'h40, SIZE_WORD, 1'b0, 32'h99999999, 32'h0, 1'b1);
    send(1'b0, 32'h40, SIZE_BYTE, 1'b1, 32'h0,        32'h0, 1'b1);
    send(1'b0, 32'h0,  SIZE_WORD, 1'b0, 32'h0,        32'h0, 1'b0);
    send(1'b0, 32'h8,  SIZE_WORD, 1'b0, 32'h0,        32'h1234BEEF, 1'b0);
    idle_settle();
    checks++;
    if (r1_d.size() != e_d.size() || r3_d.size() != e_d.size()) begin
      errors++;
      $display("FAIL err_count: got %0d/%0d, want %0d", r1_d.size(), r3_d.size(), e_d.size());
    end
    foreach (e_d[i]) begin
      checks++;
      if (r1_d[i] !== e_d[i] || r1_e[i] !== e_e[i] || r1_c[i] - a_c[i] != 0) begin
        errors++;
        $display("FAIL errors[%0d] lat1: got d=%h e=%b dly=%0d, want d=%h e=%b dly=0",
                 i, r1_d[i], r1_e[i], r1_c[i] - a_c[i], e_d[i], e_e[i]);
      end
      checks++;
      if (r3_d[i] !== e_d[i] || r3_e[i] !== e_e[i] || r3_c[i] - a_c[i] != 2) begin
        errors++;
        $display("FAIL errors[%0d] lat3: got d=%h e=%b dly=%0d, want d=%h e=%b dly=2",
                 i, r3_d[i], r3_e[i], r3_c[i] - a_c[i], e_d[i], e_e[i]);
      end
    end
  endtask

  task automatic test_stream();
    clear_q();
    send(1'b0, 32'h8, SIZE_BYTE, 1'b1, 32'h0, 32'h000000EF, 1'b0);
    send(1'b0, 32'h9, SIZE_BYTE, 1'b0, 32'h0, 32'hFFFFFFBE, 1'b0);
    send(1'b0, 32'hA, SIZE_BYTE, 1'b1, 32'h0, 32'h00000034, 1'b0);
    send(1'b0, 32'hB, SIZE_BYTE, 1'b0, 32'h0, 32'h00000012, 1'b0);
    send(1'b0, 32'hA, SIZE_HALF, 1'b1, 32'h0, 32'h00001234, 1'b0);
    send(1'b0, 32'h8, SIZE_HALF, 1'b1, 32'h0, 32'h0000BEEF, 1'b0);
    send(1'b0, 32'hC, SIZE_WORD, 1'b0, 32'h0, 32'h00000000, 1'b0);
    send(1'b0, 32'h8, SIZE_WORD, 1'b1, 32'h0, 32'h1234BEEF, 1'b0);
    idle_settle();
    checks++;
    if (r1_d.size() != 8 || r3_d.size() != 8) begin
      errors++;
      $display("FAIL stream_count: got %0d/%0d, want 8", r1_d.size(), r3_d.size());
    end
    foreach (e_d[i]) begin
      checks++;
      if (r1_d[i] !== e_d[i] || r1_e[i] !== e_e[i] || r1_c[i] - a_c[i] != 0) begin
        errors++;
        $display("FAIL stream[%0d] lat1: got d=%h e=%b dly=%0d, want d=%h e=%b dly=0",
                 i, r1_d[i], r1_e[i], r1_c[i] - a_c[i], e_d[i], e_e[i]);
      end
      checks++;
      if (r3_d[i] !== e_d[i] || r3_e[i] !== e_e[i] || r3_c[i] - a_c[i] != 2) begin
        errors++;
        $display("FAIL stream[%0d] lat3: got d=%h e=%b dly=%0d, want d=%h e=%b dly=2",
                 i, r3_d[i], r3_e[i], r3_c[i] - a_c[i], e_d[i], e_e[i]);
      end
    end
  endtask

  task automatic test_reset_inflight();
    int n;
    clear_q();
    send(1'b1, 32'h10, SIZE_WORD, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0);
    send(1'b0, 32'h10, SIZE_WORD, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
    idle_settle();
    checks++;
    if (r3_d.size() != 2 || r3_d[1] !== 32'hCAFEF00D || r1_d[1] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL pre_reset_store: got %h/%h, want cafef00d", r1_d[1], r3_d[1]);
    end
    send(1'b0, 32'h10, SIZE_WORD, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
    send(1'b0, 32'h8,  SIZE_WORD, 1'b0, 32'h0, 32'h1234BEEF, 1'b0);
    rst_n = 1'b0;
    req_valid = 1'b0;
    clear_q();
    #1;
    checks++;
    if (v1 !== 1'b0 || v3 !== 1'b0 || rdy1 !== 1'b0 || rdy3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got v=%b%b rdy=%b%b, want 0", v1, v3, rdy1, rdy3);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8; req_size = SIZE_WORD;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rdy1 || rdy3) begin n = i; break; end
    end
    req_valid = 1'b0;
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL reinit_edges: got %0d, want 16", n);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (r1_d.size() != 0 || r3_d.size() != 0) begin
      errors++;
      $display("FAIL no_rsp_after_reset: got %0d/%0d pulses, want 0", r1_d.size(), r3_d.size());
    end
    clear_q();
    send(1'b0, 32'h10, SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
    idle_settle();
    checks++;
    if (r1_d.size() != 1 || r3_d.size() != 1 || r1_d[0] !== 32'h0 || r3_d[0] !== 32'h0 ||
        r1_e[0] !== 1'b0 || r3_e[0] !== 1'b0) begin
      errors++;
      $display("FAIL cleared_word: got n=%0d/%0d d=%h/%h, want 1/1 d=0",
               r1_d.size(), r3_d.size(), r1_d[0], r3_d[0]);
    end
  endtask

  initial begin
    test_reset();
    test_init_load();
    test_bytes();
    test_back_to_back();
    test_errors();
    test_stream();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
